// File: rtl/mcb_burst_engine.sv
// rtl/mcb_burst_engine.sv - burst sequencer between a user datapath and one MCB port (cmd/wr/rd FIFOs)
// Optional read-stall timeout is compiled in with `define MCB_BURST_TIMEOUT_EN.
module mcb_burst_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LEN      = 16,
  parameter int ADDR_WIDTH     = 30,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    USER_CLK,
  input  logic                    RST_N,
  input  logic                    CALIB_DONE,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic                    WIN_VALID,
  output logic                    WIN_READY,
  input  logic [DATA_WIDTH-1:0]   WIN_DATA,
  output logic                    ROUT_VALID,
  input  logic                    ROUT_READY,
  output logic [DATA_WIDTH-1:0]   ROUT_DATA,
  output logic                    CMD_EN,
  output logic [2:0]              CMD_INSTR,
  output logic [5:0]              CMD_BL,
  output logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic                    CMD_FULL,
  output logic                    WR_EN,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic [DATA_WIDTH/8-1:0] WR_MASK,
  input  logic                    WR_FULL,
  input  logic                    WR_UNDERRUN,
  input  logic                    WR_ERROR,
  output logic                    RD_EN,
  input  logic [DATA_WIDTH-1:0]   RD_DATA,
  input  logic                    RD_EMPTY,
  input  logic                    RD_OVERFLOW,
  input  logic                    RD_ERROR,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR,
  output logic                    TIMEOUT
);

  localparam int LSB = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [6:0] LAST = 7'(BURST_LEN - 1);
  // An illegal parameter set leaves the engine permanently unready rather than issuing malformed bursts.
  localparam bit CFG_OK = (DATA_WIDTH == 32 || DATA_WIDTH == 64 || DATA_WIDTH == 128) &&
                          (BURST_LEN >= 1) && (BURST_LEN <= 64) && (TIMEOUT_CYCLES >= 1);

  typedef enum logic [2:0] {S_IDLE, S_WR_FILL, S_WR_CMD, S_RD_CMD, S_RD_DRAIN} state_t;

  state_t                  state, state_nx;
  logic [6:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [5:0]              bl_q;
  logic [2:0]              instr_q;
  logic                    ready_q;
  logic                    done_q, done_nx;
  logic                    err_q;
  logic                    accept, wr_beat, rd_beat, cmd_go, tmo_hit;

  assign accept  = (state == S_IDLE) & CALIB_DONE & ready_q & CFG_OK & REQ_VALID;
  assign wr_beat = (state == S_WR_FILL) & WIN_VALID & ~WR_FULL;
  assign rd_beat = (state == S_RD_DRAIN) & ~RD_EMPTY & ROUT_READY;
  assign cmd_go  = ((state == S_WR_CMD) | (state == S_RD_CMD)) & ~CMD_FULL;

  // Next-state and per-state handshake outputs.
  always_comb begin
    state_nx   = state;
    done_nx    = 1'b0;
    REQ_READY  = 1'b0;
    WIN_READY  = 1'b0;
    WR_EN      = 1'b0;
    CMD_EN     = 1'b0;
    ROUT_VALID = 1'b0;
    RD_EN      = 1'b0;
    case (state)
      S_IDLE: begin
        REQ_READY = CALIB_DONE & ready_q & CFG_OK;
        if (accept) state_nx = REQ_WRITE ? S_WR_FILL : S_RD_CMD;
      end
      S_WR_FILL: begin
        WIN_READY = ~WR_FULL;
        WR_EN     = wr_beat;
        if (wr_beat && cnt == LAST) state_nx = S_WR_CMD;
      end
      S_WR_CMD: begin
        CMD_EN = cmd_go;
        if (cmd_go) begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_RD_CMD: begin
        CMD_EN = cmd_go;
        if (cmd_go) state_nx = S_RD_DRAIN;
      end
      S_RD_DRAIN: begin
        ROUT_VALID = ~RD_EMPTY;
        RD_EN      = rd_beat;
        if ((rd_beat && cnt == LAST) || tmo_hit) begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, beat counter, latched command fields, done pulse and sticky error.
  always_ff @(posedge USER_CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      cnt     <= 7'd0;
      addr_q  <= '0;
      bl_q    <= 6'd0;
      instr_q <= 3'b000;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= 1'b1;
      done_q  <= done_nx;
      err_q   <= err_q | WR_UNDERRUN | WR_ERROR | RD_OVERFLOW | RD_ERROR | tmo_hit;
      if (state == S_IDLE) cnt <= 7'd0;
      else if (wr_beat || rd_beat) cnt <= cnt + 7'd1;
      if (accept) begin
        addr_q  <= REQ_ADDR & ADDR_MASK;
        bl_q    <= 6'(BURST_LEN - 1);
        instr_q <= REQ_WRITE ? 3'b000 : 3'b001;
      end
    end
  end

`ifdef MCB_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          tmo_q;

  // Firing on the last idle count makes DONE/ERR/TIMEOUT visible exactly TIMEOUT_CYCLES after drain starts.
  assign tmo_hit = (state == S_RD_DRAIN) & ~rd_beat & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT = tmo_q;

  // Idle-cycle counter for the drain phase plus the sticky timeout flag.
  always_ff @(posedge USER_CLK) begin
    if (!RST_N) begin
      tcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (state != S_RD_DRAIN || rd_beat) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  assign CMD_INSTR = instr_q;
  assign CMD_BL    = bl_q;
  assign CMD_ADDR  = addr_q;
  assign WR_DATA   = WIN_DATA;
  assign WR_MASK   = '0;
  assign ROUT_DATA = RD_DATA;
  assign BUSY      = (state != S_IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_mcb_burst_engine.sv
// tb/tb_mcb_burst_engine.sv - randomized self-checking bench for mcb_burst_engine
module tb_mcb_burst_engine;
  localparam int DW = 32;
  localparam int BL = 16;
  localparam int AW = 30;
  localparam int TO = 8;

  logic          USER_CLK = 1'b0;
  logic          RST_N = 1'b0, CALIB_DONE = 1'b1;
  logic          REQ_VALID = 1'b0, REQ_WRITE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic          WIN_VALID = 1'b0, ROUT_READY = 1'b1, CMD_FULL = 1'b0, WR_FULL = 1'b0;
  logic [DW-1:0] WIN_DATA = '0, RD_DATA = '0;
  logic          WR_UNDERRUN = 1'b0, WR_ERROR = 1'b0, RD_EMPTY = 1'b1, RD_OVERFLOW = 1'b0, RD_ERROR = 1'b0;
  logic          REQ_READY, WIN_READY, ROUT_VALID, CMD_EN, WR_EN, RD_EN, BUSY, DONE, ERR, TIMEOUT;
  logic [DW-1:0] ROUT_DATA, WR_DATA;
  logic [DW/8-1:0] WR_MASK;
  logic [2:0]    CMD_INSTR;
  logic [5:0]    CMD_BL;
  logic [AW-1:0] CMD_ADDR;

  mcb_burst_engine #(.DATA_WIDTH(DW), .BURST_LEN(BL), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .USER_CLK(USER_CLK), .RST_N(RST_N), .CALIB_DONE(CALIB_DONE),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .WIN_VALID(WIN_VALID), .WIN_READY(WIN_READY), .WIN_DATA(WIN_DATA),
    .ROUT_VALID(ROUT_VALID), .ROUT_READY(ROUT_READY), .ROUT_DATA(ROUT_DATA),
    .CMD_EN(CMD_EN), .CMD_INSTR(CMD_INSTR), .CMD_BL(CMD_BL), .CMD_ADDR(CMD_ADDR), .CMD_FULL(CMD_FULL),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_MASK(WR_MASK), .WR_FULL(WR_FULL),
    .WR_UNDERRUN(WR_UNDERRUN), .WR_ERROR(WR_ERROR),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_EMPTY(RD_EMPTY), .RD_OVERFLOW(RD_OVERFLOW), .RD_ERROR(RD_ERROR),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .TIMEOUT(TIMEOUT)
  );

  always #5 USER_CLK = ~USER_CLK;

  int n_chk = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0, cmd_cyc = 0, done_cyc = 0, first_wr_cyc = 0, first_rd_cyc = 0, last_rout_cyc = 0;
  int done_cnt = 0, cmd_total = 0;
  bit stall_en = 0, ovf_arm = 0, rd_pop = 0;
  logic [DW-1:0] win_q[$], rd_fifo[$], wr_got[$], rout_got[$], exp_wr[$], exp_rd[$];
  logic [2:0]    ci_q[$];
  logic [5:0]    cb_q[$];
  logic [AW-1:0] ca_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // MCB FIFO / stream environment: observe at negedge, drive just after posedge.
  initial begin
    forever begin
      @(negedge USER_CLK);
      cyc++;
      rd_pop = RD_EN;
      if (WR_EN) begin
        if (wr_got.size() == 0) first_wr_cyc = cyc;
        wr_got.push_back(WR_DATA);
      end
      if (WIN_VALID && WIN_READY && win_q.size() > 0) win_q.delete(0);
      if (ROUT_VALID && ROUT_READY) begin
        if (rout_got.size() == 0) first_rd_cyc = cyc;
        rout_got.push_back(ROUT_DATA);
        last_rout_cyc = cyc;
      end
      if (CMD_EN) begin
        cmd_cyc = cyc; cmd_total++;
        ci_q.push_back(CMD_INSTR); cb_q.push_back(CMD_BL); ca_q.push_back(CMD_ADDR);
      end
      if (DONE) begin done_cnt++; done_cyc = cyc; end
      if (REQ_VALID && REQ_READY) acc_cyc = cyc;
      @(posedge USER_CLK); #1;
      if (rd_pop && rd_fifo.size() > 0) rd_fifo.delete(0);
      RD_DATA    = (rd_fifo.size() > 0) ? rd_fifo[0] : '0;
      RD_EMPTY   = (rd_fifo.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
      WIN_DATA   = (win_q.size() > 0) ? win_q[0] : '0;
      WIN_VALID  = (win_q.size() > 0) && (!stall_en || $urandom_range(0, 3) != 0);
      WR_FULL    = stall_en && $urandom_range(0, 2) == 0;
      CMD_FULL   = stall_en && $urandom_range(0, 1) == 0;
      ROUT_READY = !stall_en || $urandom_range(0, 2) != 0;
      RD_OVERFLOW = 1'b0;
      if (ovf_arm && rout_got.size() >= BL / 2) begin RD_OVERFLOW = 1'b1; ovf_arm = 0; end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset(input string pfx);
    chk({pfx, "_ctl"}, 64'({REQ_READY, WIN_READY, ROUT_VALID, CMD_EN, WR_EN, RD_EN, BUSY, DONE, ERR, TIMEOUT}), 64'd0);
    chk({pfx, "_cmd"}, 64'({CMD_INSTR, CMD_BL, CMD_ADDR}), 64'd0);
    chk({pfx, "_mask"}, 64'(WR_MASK), 64'd0);
  endtask

  task automatic clear_logs();
    wr_got.delete(); rout_got.delete(); exp_wr.delete(); exp_rd.delete();
    ci_q.delete(); cb_q.delete(); ca_q.delete();
  endtask

  task automatic issue_req(input bit wr, input logic [AW-1:0] a);
    int n = 0;
    REQ_WRITE = wr; REQ_ADDR = a; REQ_VALID = 1'b1;
    do begin @(negedge USER_CLK); n++; end while (!REQ_READY && n < 200);
    chk("req_accept", 64'(REQ_READY), 64'd1);
    @(posedge USER_CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge USER_CLK); n++; end while (!DONE && n < 3000);
    chk("done_seen", 64'(DONE), 64'd1);
    @(posedge USER_CLK); #1;
  endtask

  task automatic check_burst(input bit wr, input logic [AW-1:0] a, input int d0);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    if (wr) begin
      chk("wr_words", 64'(wr_got.size()), 64'(BL));
      for (int i = 0; i < wr_got.size() && i < BL; i++) chk("wr_data", 64'(wr_got[i]), 64'(exp_wr[i]));
    end else begin
      chk("rd_words", 64'(rout_got.size()), 64'(BL));
      for (int i = 0; i < rout_got.size() && i < BL; i++) chk("rd_data", 64'(rout_got[i]), 64'(exp_rd[i]));
    end
    chk("cmd_count", 64'(ci_q.size()), 64'd1);
    if (ci_q.size() > 0) begin
      chk("cmd_instr", 64'(ci_q[0]), wr ? 64'd0 : 64'd1);
      chk("cmd_bl", 64'(cb_q[0]), 64'(BL - 1));
      chk("cmd_addr", 64'(ca_q[0]), 64'(a & ~AW'(DW / 8 - 1)));
    end
  endtask

  task automatic do_burst(input bit wr, input logic [AW-1:0] a, input bit timing);
    int d0;
    logic [DW-1:0] w;
    clear_logs();
    for (int i = 0; i < BL; i++) begin
      w = $urandom;
      if (wr) begin win_q.push_back(w); exp_wr.push_back(w); end
      else begin rd_fifo.push_back(w); exp_rd.push_back(w); end
    end
    d0 = done_cnt;
    issue_req(wr, a);
    wait_done();
    check_burst(wr, a, d0);
    if (timing && wr) begin
      chk("wr_first_lat", 64'(first_wr_cyc - acc_cyc), 64'd1);
      chk("wr_cmd_lat", 64'(cmd_cyc - acc_cyc), 64'(BL + 1));
      chk("wr_done_lat", 64'(done_cyc - acc_cyc), 64'(BL + 2));
    end
    if (timing && !wr) begin
      chk("rd_cmd_lat", 64'(cmd_cyc - acc_cyc), 64'd1);
      chk("rd_first_lat", 64'(first_rd_cyc - acc_cyc), 64'd2);
      chk("rd_done_lat", 64'(done_cyc - last_rout_cyc), 64'd1);
    end
  endtask

  initial begin
    int prev, n, c0, d0;
    bit seen, wr;
    logic [AW-1:0] a;

    repeat (3) @(posedge USER_CLK);
    @(negedge USER_CLK);
    chk_reset("reset");
    @(posedge USER_CLK); #1;
    RST_N = 1'b1;

    do_burst(1'b1, 30'h0000_0103, 1'b1);
    do_burst(1'b0, 30'h0000_2208, 1'b1);
    chk("err_after_clean", 64'(ERR), 64'd0);

    stall_en = 1;
    for (int k = 0; k < 8; k++) begin
      wr = 1'($urandom_range(0, 1));
      a = AW'($urandom);
      prev = done_cyc;
      do_burst(wr, a, 1'b0);
      chk("back_to_back", 64'(acc_cyc - prev), 64'd1);
    end
    stall_en = 0;

    CALIB_DONE = 1'b0; REQ_WRITE = 1'b0; REQ_VALID = 1'b1;
    c0 = cmd_total; seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge USER_CLK);
      if (REQ_READY || BUSY) seen = 1;
    end
    chk("calib_blocked", 64'(seen), 64'd0);
    chk("calib_no_cmd", 64'(cmd_total - c0), 64'd0);
    @(posedge USER_CLK); #1;
    REQ_VALID = 1'b0; CALIB_DONE = 1'b1;

    chk("err_before_ovf", 64'(ERR), 64'd0);
    stall_en = 1; ovf_arm = 1;
    do_burst(1'b0, AW'($urandom), 1'b0);
    stall_en = 0;
    chk("err_sticky", 64'(ERR), 64'd1);
    repeat (3) @(posedge USER_CLK); #1;
    chk("err_still", 64'(ERR), 64'd1);

    clear_logs();
    for (int i = 0; i < BL; i++) win_q.push_back($urandom);
    issue_req(1'b1, 30'h0000_4444);
    n = 0;
    do begin @(negedge USER_CLK); n++; end while (wr_got.size() < 5 && n < 200);
    chk("midrst_progress", 64'(BUSY), 64'd1);
    @(posedge USER_CLK); #1; RST_N = 1'b0;
    @(posedge USER_CLK); #1; RST_N = 1'b1;
    @(negedge USER_CLK);
    chk_reset("midrst");
    win_q.delete();
    @(negedge USER_CLK);
    chk("midrst_ready", 64'({REQ_READY, BUSY}), 64'b10);

    @(posedge USER_CLK); #1;
    clear_logs();
    d0 = done_cnt;
    issue_req(1'b0, 30'h0000_0040);
`ifdef MCB_BURST_TIMEOUT_EN
    wait_done();
    chk("tmo_latency", 64'(done_cyc - cmd_cyc), 64'(TO + 1));
    chk("tmo_flag", 64'(TIMEOUT), 64'd1);
    chk("tmo_err", 64'(ERR), 64'd1);
    chk("tmo_no_data", 64'(rout_got.size()), 64'd0);
    chk("tmo_done_once", 64'(done_cnt - d0), 64'd1);
    chk("tmo_idle", 64'(BUSY), 64'd0);
`else
    seen = 0;
    for (int i = 0; i < 5 * TO; i++) begin
      @(negedge USER_CLK);
      if (DONE || TIMEOUT) seen = 1;
    end
    chk("no_tmo_waits", 64'(seen), 64'd0);
    chk("no_tmo_busy", 64'(BUSY), 64'd1);
    @(posedge USER_CLK); #1;
    for (int i = 0; i < BL; i++) begin
      exp_rd.push_back($urandom);
      rd_fifo.push_back(exp_rd[i]);
    end
    wait_done();
    check_burst(1'b0, 30'h0000_0040, d0);
    chk("no_tmo_flag", 64'({TIMEOUT, ERR}), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mcb_burst_engine.md
# mcb_burst_engine

Parametrised burst sequencer on the user side of one MCB port, between the datapath and the MCB port FIFOs (cmd/wr/rd, all on USER_CLK).
- Accepts single read/write burst requests.
- For writes: streams BURST_LEN words into the MCB write FIFO, then issues the command.
- For reads: issues the command, then streams BURST_LEN words out of the MCB read FIFO.
- Generalises the fixed 32-bit single-word port usage to configurable data width and burst length, with sticky error capture and an optional read timeout.

## Interface
Parameters:
- DATA_WIDTH, 32, port data width; legal values 32/64/128; mask width is DATA_WIDTH/8
- BURST_LEN, 16, words per burst, 1..64; driven on CMD_BL as BURST_LEN-1
- ADDR_WIDTH, 30, byte address width
- TIMEOUT_CYCLES, 1024, read stall limit; used only with MCB_BURST_TIMEOUT_EN

Ports:
- USER_CLK  in  1  single clock for the block and all MCB port FIFOs
- RST_N  in  1  reset, synchronous, active-low
- CALIB_DONE  in  1  MCB calibration complete
- REQ_VALID / REQ_READY  in/out  1  request handshake
- REQ_WRITE  in  1  1 = write burst, 0 = read burst
- REQ_ADDR  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits forced to 0
- WIN_VALID / WIN_READY  in/out  1  write-data stream handshake
- WIN_DATA  in  DATA_WIDTH  write data
- ROUT_VALID / ROUT_READY  out/in  1  read-data stream handshake
- ROUT_DATA  out  DATA_WIDTH  read data
- CMD_EN, CMD_INSTR[2:0], CMD_BL[5:0], CMD_ADDR[ADDR_WIDTH-1:0]  out  MCB command
- CMD_FULL  in  1
- WR_EN  out  1
- WR_DATA  out  DATA_WIDTH
- WR_MASK  out  DATA_WIDTH/8  constant 0
- WR_FULL, WR_UNDERRUN, WR_ERROR  in  1
- RD_EN  out  1
- RD_DATA  in  DATA_WIDTH
- RD_EMPTY, RD_OVERFLOW, RD_ERROR  in  1
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse per completed or aborted burst
- ERR  out  1  sticky error
- TIMEOUT  out  1  sticky, timeout cause

## Operation
States: IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN.

- IDLE:
  - REQ_READY = CALIB_DONE.
  - On accept, latch address and type; go to WR_FILL (write) or RD_CMD (read).
- WR_FILL:
  - WIN_READY = ~WR_FULL; WR_EN = WIN_VALID & ~WR_FULL; WR_DATA = WIN_DATA.
  - Word counter increments per WR_EN.
  - After word BURST_LEN-1 is written, go to WR_CMD.
- WR_CMD:
  - CMD_EN = ~CMD_FULL, CMD_INSTR = 3'b000.
  - When issued, pulse DONE and go to IDLE.
- RD_CMD:
  - CMD_EN = ~CMD_FULL, CMD_INSTR = 3'b001.
  - When issued, go to RD_DRAIN.
- RD_DRAIN:
  - ROUT_VALID = ~RD_EMPTY; ROUT_DATA = RD_DATA (first-word-fall-through); RD_EN = ROUT_VALID & ROUT_READY.
  - After word BURST_LEN-1 transfers, pulse DONE and go to IDLE.
- CMD_ADDR and CMD_BL are held stable from request accept until the command issues.
- ERR is set by any of WR_UNDERRUN, WR_ERROR, RD_OVERFLOW, RD_ERROR (or a timeout); only reset clears it. Setting ERR does not alter the state sequence.
- CALIB_DONE falling only blocks new requests; a burst already in progress completes.
- Reset mid-burst: state returns to IDLE and counters clear. Words already pushed into the MCB FIFOs are not flushed; the system must also reset the MCB.

## Timing
- Reset values: REQ_READY, WIN_READY, ROUT_VALID, CMD_EN, WR_EN, RD_EN, BUSY, DONE, ERR, TIMEOUT all 0. CMD_INSTR, CMD_BL, CMD_ADDR are 0.
- Write, with no FIFO stalls:
  - request accepted at cycle t; words written t+1..t+BURST_LEN;
  - CMD_EN at t+BURST_LEN+1;
  - DONE and REQ_READY at t+BURST_LEN+2.
- Read:
  - accept at t, CMD_EN at t+1 (if CMD_FULL low), drain from t+2;
  - DONE the cycle after the last RD_EN.
- CMD_FULL, WR_FULL, RD_EMPTY, ROUT_READY each stall by whole cycles, with no data loss or duplication.
- BURST_LEN = 1 is legal: write is one fill cycle, then the command.
- Back-to-back: a new request can be accepted the cycle after DONE.

## Configuration
- MCB_BURST_TIMEOUT_EN defined:
  - A counter in RD_DRAIN clears on each RD_EN and increments otherwise.
  - On reaching TIMEOUT_CYCLES: set ERR and TIMEOUT, pulse DONE, go to IDLE.
  - The remaining words stay in the MCB read FIFO.
- Undefined: no counter; RD_DRAIN waits indefinitely; TIMEOUT tied to 0.

## Test plan
- Write, DATA_WIDTH=32, BURST_LEN=16, REQ_ADDR=0x0000_0103:
  - 16 WR_EN pulses, then one CMD_EN with INSTR=000, BL=15, ADDR=0x0000_0100;
  - DONE 18 cycles after accept.
- Read, same burst length, RD_EMPTY low throughout:
  - CMD_EN with INSTR=001 at t+1;
  - 16 ROUT beats equal to RD_DATA, in order;
  - DONE once; ERR=0.
- Stalls:
  - Toggle WR_FULL, CMD_FULL and ROUT_READY randomly.
  - Required: exactly BURST_LEN words each way, no duplicates, one CMD_EN per burst.
- Errors and calibration:
  - Pulse RD_OVERFLOW mid-drain: ERR stays 1 after the burst completes normally.
  - CALIB_DONE=0 in IDLE: REQ_READY=0 and no CMD_EN.
- Reset and timeout:
  - Drop RST_N for 1 cycle mid-WR_FILL: next cycle all outputs are at reset values and state is IDLE.
  - With MCB_BURST_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold RD_EMPTY=1: DONE, ERR and TIMEOUT 8 cycles after entering RD_DRAIN.
